// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the single-port frame buffer between display reads and processor read/write with starvation guard and lock handshake
module frame_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic              proc_gnt,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_rvalid,
    input  logic              lock_req,
    output logic              lock_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [15:0]       disp_miss_cnt
);
    localparam int SW = 4;
    localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

    typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} state_t;
    typedef enum logic [1:0] {NONE, DISP, PROC} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [15:0]       miss_q, miss_d;
    logic              lock_ack_q;
    logic [DATA_W-1:0] disp_hold_q, proc_hold_q;

    // Arbitration, memory steering, read-return muxing and next-state logic
    always_comb begin
        disp_gnt    = rst && state_q == SHARED && disp_req && !(proc_req && starve_q == MAXW);
        proc_gnt    = rst && proc_req && (state_q == LOCKED ||
                      (state_q == SHARED && !(disp_req && starve_q != MAXW)));
        mem_addr    = proc_gnt ? proc_addr : disp_addr;
        mem_data    = proc_wdata;
        mem_wren    = proc_gnt && proc_we;
        disp_rvalid = owner_q == DISP;
        proc_rvalid = owner_q == PROC;
        disp_rdata  = disp_rvalid ? mem_q : disp_hold_q;
        proc_rdata  = proc_rvalid ? mem_q : proc_hold_q;
        state_d     = !lock_req ? SHARED : (state_q == SHARED ? DRAIN : LOCKED);
        owner_d     = disp_gnt ? DISP : ((proc_gnt && !proc_we) ? PROC : NONE);
        starve_d    = (proc_req && !proc_gnt) ? (starve_q == MAXW ? starve_q : starve_q + SW'(1)) : '0;
        miss_d      = (disp_req && !disp_gnt && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
        lock_ack      = lock_ack_q;
        disp_miss_cnt = miss_q;
    end

    // State, counters and held read data; reset is synchronous and active-low
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SHARED;
            owner_q     <= NONE;
            starve_q    <= '0;
            miss_q      <= '0;
            lock_ack_q  <= 1'b0;
            disp_hold_q <= '0;
            proc_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            miss_q      <= miss_d;
            lock_ack_q  <= state_d == LOCKED;
            disp_hold_q <= disp_rdata;
            proc_hold_q <= proc_rdata;
        end
    end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed self-checking bench for frame_mem_arbiter with a behavioural RAM
module tb_frame_mem_arbiter;
    logic        clk = 0;
    logic        rst = 0;
    logic        disp_req = 0, proc_req = 0, proc_we = 0, lock_req = 0;
    logic [14:0] disp_addr = 0, proc_addr = 0;
    logic [23:0] proc_wdata = 0;
    logic        disp_gnt, disp_rvalid, proc_gnt, proc_rvalid, lock_ack, mem_wren;
    logic [23:0] disp_rdata, proc_rdata, mem_data, mem_q;
    logic [14:0] mem_addr;
    logic [15:0] disp_miss_cnt;
    logic [23:0] ram [0:32767];
    int          tests = 0, fails = 0;

    frame_mem_arbiter #(.ADDR_W(15), .DATA_W(24), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_gnt(proc_gnt), .proc_rdata(proc_rdata),
        .proc_rvalid(proc_rvalid), .lock_req(lock_req), .lock_ack(lock_ack),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .disp_miss_cnt(disp_miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = '0;
        ram[100] = 24'hABCDEF;
        ram[5]   = 24'h555555;
        disp_req = 1; proc_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_disp_gnt", disp_gnt, 0);
            check("rst_proc_gnt", proc_gnt, 0);
            check("rst_wren", mem_wren, 0);
            check("rst_lock_ack", lock_ack, 0);
            check("rst_rvalids", {disp_rvalid, proc_rvalid}, 0);
            check("rst_miss", disp_miss_cnt, 0);
        end
        @(negedge clk);
        rst = 1; disp_req = 1; disp_addr = 100; proc_req = 0;
        #1;
        check("dread_gnt", disp_gnt, 1);
        check("dread_pgnt", proc_gnt, 0);
        check("dread_addr", mem_addr, 100);
        @(negedge clk);
        disp_req = 0;
        #1;
        check("dread_rvalid", disp_rvalid, 1);
        check("dread_rdata", disp_rdata, 24'hABCDEF);
        check("dread_prvalid", proc_rvalid, 0);
        check("dread_miss", disp_miss_cnt, 0);
        @(negedge clk);
        disp_req = 1; proc_req = 1; proc_we = 0; proc_addr = 5;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("cont_dgnt", disp_gnt, (i % 5) != 4);
            check("cont_pgnt", proc_gnt, (i % 5) == 4);
            if (i == 5) begin
                check("cont_prvalid", proc_rvalid, 1);
                check("cont_prdata", proc_rdata, 24'h555555);
            end
            @(negedge clk);
        end
        check("cont_miss", disp_miss_cnt, 2);
        disp_req = 0; proc_req = 0; lock_req = 1;
        #1;
        check("lock_t_ack", lock_ack, 0);
        @(negedge clk);
        disp_req = 1; proc_req = 1; proc_we = 1; proc_addr = 5; proc_wdata = 24'h123456;
        #1;
        check("drain_dgnt", disp_gnt, 0);
        check("drain_pgnt", proc_gnt, 0);
        check("drain_ack", lock_ack, 0);
        @(negedge clk); #1;
        check("locked_ack", lock_ack, 1);
        check("locked_pgnt", proc_gnt, 1);
        check("locked_dgnt", disp_gnt, 0);
        check("locked_wren", mem_wren, 1);
        check("locked_addr", mem_addr, 5);
        check("locked_data", mem_data, 24'h123456);
        @(negedge clk);
        proc_we = 0;
        #1;
        check("lread_pgnt", proc_gnt, 1);
        check("lread_wren", mem_wren, 0);
        @(negedge clk);
        proc_req = 0; lock_req = 0;
        #1;
        check("lread_rvalid", proc_rvalid, 1);
        check("lread_rdata", proc_rdata, 24'h123456);
        check("lread_dgnt", disp_gnt, 0);
        @(negedge clk); #1;
        check("unlock_ack", lock_ack, 0);
        check("unlock_dgnt", disp_gnt, 1);
        check("unlock_miss", disp_miss_cnt, 6);
        check("hold_prdata", proc_rdata, 24'h123456);
        @(negedge clk);
        disp_req = 0; lock_req = 1;
        @(negedge clk);
        lock_req = 0;
        #1;
        check("abort_drain_dgnt", disp_gnt, 0);
        @(negedge clk);
        disp_req = 1;
        #1;
        check("abort_ack", lock_ack, 0);
        check("abort_dgnt", disp_gnt, 1);
        @(negedge clk); #1;
        check("abort_ack2", lock_ack, 0);
        lock_req = 1;
        repeat (70000) @(negedge clk);
        #1;
        check("sat_miss", disp_miss_cnt, 16'hFFFF);
        check("sat_ack", lock_ack, 1);
        rst = 0;
        @(negedge clk); #1;
        check("rst2_ack", lock_ack, 0);
        check("rst2_miss", disp_miss_cnt, 0);
        check("rst2_dgnt", disp_gnt, 0);
        rst = 1; lock_req = 0;
        #1;
        check("rst2_shared_dgnt", disp_gnt, 1);
        @(negedge clk); #1;
        check("rst2_ack_after", lock_ack, 0);
        check("rst2_miss_after", disp_miss_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
